// File: rtl/peak_hold.sv
// Level meter with ballistic bar level and a peak-hold marker (IDLE/HOLD/DECAY).
// Optional sticky clip flag with clip_clr, built only when PEAK_HOLD_CLIP_EN is defined.
module peak_hold #(
    parameter int HOLD_FRAMES = 50,
    parameter int DECAY_STEP  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       load,
    input  logic       frame_tick,
    output logic [7:0] level,
    output logic [7:0] peak,
    output logic       hold_active
`ifdef PEAK_HOLD_CLIP_EN
    ,
    output logic       clip,
    input  logic       clip_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);
    localparam logic [7:0] STEP      = 8'(DECAY_STEP);

    state_t     state_q, state_d;
    logic [7:0] level_q, level_d;
    logic [7:0] peak_q, peak_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       hold_active_q, hold_active_d;
    logic [7:0] peak_dec;
    logic       capture;

    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        level_d    = level_q;
        peak_d     = peak_q;
        hold_cnt_d = hold_cnt_q;
        peak_dec   = (peak_q != 8'd0) ? peak_q - 8'd1 : 8'd0;
        capture    = 1'b0;

        if (enable) begin
            // The sample is evaluated first; decay only touches what the sample left alone.
            if (load && (data_in >= level_q)) begin
                level_d = data_in;
            end else if (frame_tick) begin
                level_d = (level_q > STEP) ? level_q - STEP : 8'd0;
            end

            capture = load && (data_in >= peak_q);
            if (capture) begin
                peak_d     = data_in;
                hold_cnt_d = HOLD_INIT;
                state_d    = HOLD;
            end else if (frame_tick) begin
                case (state_q)
                    HOLD: begin
                        if (hold_cnt_q <= 8'd1) begin
                            hold_cnt_d = 8'd0;
                            state_d    = DECAY;
                        end else begin
                            hold_cnt_d = hold_cnt_q - 8'd1;
                        end
                    end
                    DECAY: begin
                        // Marker never falls below the bar it is marking.
                        peak_d = (peak_dec > level_d) ? peak_dec : level_d;
                        if (peak_d == 8'd0) begin
                            state_d = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        hold_active_d = (state_d == HOLD);
    end

    // NOTE: asynchronous active-low reset; state updates use non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            level_q       <= 8'd0;
            peak_q        <= 8'd0;
            hold_cnt_q    <= 8'd0;
            hold_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            peak_q        <= peak_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_active_q <= hold_active_d;
        end
    end

    assign level       = level_q;
    assign peak        = peak_q;
    assign hold_active = hold_active_q;

`ifdef PEAK_HOLD_CLIP_EN
    logic clip_q, clip_d;

    // Set wins over a simultaneous clear.
    always_comb begin
        clip_d = clip_q;
        if (enable) begin
            if (load && (data_in == 8'd255)) begin
                clip_d = 1'b1;
            end else if (clip_clr) begin
                clip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clip_q <= 1'b0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip = clip_q;
`endif

endmodule

// File: tb/tb_peak_hold.sv
// Directed, table-driven bench for peak_hold with default parameters (HOLD_FRAMES=50, DECAY_STEP=4).
// Clip checks are compiled only when PEAK_HOLD_CLIP_EN is defined.
module tb_peak_hold;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] data_in;
    logic       load;
    logic       frame_tick;
    logic [7:0] level;
    logic [7:0] peak;
    logic       hold_active;
`ifdef PEAK_HOLD_CLIP_EN
    logic       clip;
    logic       clip_clr;
`endif

    int checks = 0;
    int errors = 0;

    peak_hold dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .load       (load),
        .frame_tick (frame_tick),
        .level      (level),
        .peak       (peak),
        .hold_active(hold_active)
`ifdef PEAK_HOLD_CLIP_EN
        ,
        .clip       (clip),
        .clip_clr   (clip_clr)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic       ld;
        logic       tk;
        logic [7:0] d;
        logic [7:0] exp_level;
        logic [7:0] exp_peak;
        logic       exp_hold;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_out(input string name, input int l, input int p, input int h);
        check({name, ".level"}, int'(level), l);
        check({name, ".peak"}, int'(peak), p);
        check({name, ".hold_active"}, int'(hold_active), h);
    endtask

    // Drive on the falling edge, let one rising edge pass, settle 1 time unit.
    task automatic cycle(input logic en, input logic ld, input logic tk, input logic [7:0] d);
        @(negedge clock);
        enable     = en;
        load       = ld;
        frame_tick = tk;
        data_in    = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        enable     = 1'b1;
        load       = 1'b0;
        frame_tick = 1'b0;
        data_in    = 8'd0;
`ifdef PEAK_HOLD_CLIP_EN
        clip_clr   = 1'b0;
`endif
        reset      = 1'b0;
        #2;
        check_out("reset", 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        load       = 1'b0;
        frame_tick = 1'b0;
        data_in    = 8'd0;
`ifdef PEAK_HOLD_CLIP_EN
        clip_clr   = 1'b0;
`endif

        //            en    ld    tk    d        level    peak     hold
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'd200, 8'd200, 8'd200, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'd50,  8'd200, 8'd200, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'd0,   8'd196, 8'd200, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'd198, 8'd198, 8'd200, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'd255, 8'd198, 8'd200, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 8'd100, 8'd194, 8'd200, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 8'd200, 8'd200, 8'd200, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd200, 8'd200, 1'b1};

        #3;
        reset = 1'b0;
        #2;
        check_out("por", 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].en, vecs[i].ld, vecs[i].tk, vecs[i].d);
            check_out($sformatf("vec%0d", i), vecs[i].exp_level, vecs[i].exp_peak,
                      vecs[i].exp_hold);
        end
        check("vec7.hold_cnt", int'(dut.hold_cnt_q), 50);

        // Hold for 49 ticks, DECAY entered on tick 50, marker starts falling on tick 51.
        for (int k = 1; k <= 51; k++) begin
            int exp_l;
            exp_l = 200 - 4 * k;
            if (exp_l < 0) exp_l = 0;
            cycle(1'b1, 1'b0, 1'b1, 8'd0);
            check_out($sformatf("hold_tick%0d", k), exp_l, (k <= 50) ? 200 : 199,
                      (k < 50) ? 1 : 0);
        end

        // Marker decays by 1 per tick down to 0, then IDLE.
        for (int k = 1; k <= 199; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 8'd0);
            check($sformatf("decay_tick%0d.peak", k), int'(peak), 199 - k);
        end
        check("decay_end.hold_active", int'(hold_active), 0);

        // Zero-valued sample from IDLE still captures and enters HOLD.
        cycle(1'b1, 1'b1, 1'b0, 8'd0);
        check_out("idle_load0", 0, 0, 1);

        // Capture during DECAY with a simultaneous tick.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'd100);
        for (int k = 1; k <= 50; k++) cycle(1'b1, 1'b0, 1'b1, 8'd0);
        check_out("decay100", 0, 100, 0);
        cycle(1'b1, 1'b1, 1'b1, 8'd120);
        check_out("recapture", 120, 120, 1);
        check("recapture.hold_cnt", int'(dut.hold_cnt_q), 50);
        for (int k = 1; k <= 49; k++) cycle(1'b1, 1'b0, 1'b1, 8'd0);
        check("recapture_t49.hold_active", int'(hold_active), 1);
        cycle(1'b1, 1'b0, 1'b1, 8'd0);
        check("recapture_t50.hold_active", int'(hold_active), 0);

        // Small sample below the bar in DECAY leaves everything alone.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'd12);
        for (int k = 1; k <= 50; k++) cycle(1'b1, 1'b0, 1'b1, 8'd0);
        cycle(1'b1, 1'b0, 1'b1, 8'd0);
        check_out("setup11", 0, 11, 0);
        cycle(1'b1, 1'b1, 1'b1, 8'd10);
        check_out("setup10", 10, 10, 0);
        cycle(1'b1, 1'b1, 1'b0, 8'd3);
        check_out("small_load", 10, 10, 0);
        cycle(1'b1, 1'b0, 1'b1, 8'd0);
        check_out("small_tick", 6, 9, 0);

        // Reset pulsed between edges mid-HOLD.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'd200);
        cycle(1'b1, 1'b0, 1'b1, 8'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        check_out("pre_async", 196, 200, 1);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 8'd0);
        check_out("post_reset_tick", 0, 0, 0);
        cycle(1'b1, 1'b1, 1'b0, 8'd5);
        check_out("first_load", 5, 5, 1);

        // Disabled block ignores everything but reset.
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_out("reset_while_disabled", 0, 0, 0);
        reset = 1'b1;

`ifdef PEAK_HOLD_CLIP_EN
        do_reset();
        check("clip.reset", int'(clip), 0);
        cycle(1'b1, 1'b1, 1'b0, 8'd255);
        check("clip.set", int'(clip), 1);
        @(negedge clock);
        clip_clr = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 8'd255);
        check("clip.set_and_clr", int'(clip), 1);
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        check("clip.clr", int'(clip), 0);
        @(negedge clock);
        clip_clr = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_hold.md
PEAK_HOLD -- requirements
Module: peak_hold

Interface
REQ-001 The block SHALL have parameter HOLD_FRAMES, default 50, meaning the number of frame ticks the peak is held; legal range 1..255.
REQ-002 The block SHALL have parameter DECAY_STEP, default 4, meaning the level decrement per frame tick; legal range 1..255.
REQ-003 Port `clock`  input  1  the single clock; all state is on its rising edge.
REQ-004 Port `reset`  input  1  asynchronous, active-low reset.
REQ-005 Port `enable`  input  1  when low, all state freezes and `load`/`frame_tick` are ignored.
REQ-006 Port `data_in`  input  8  unsigned sample from the receive latch.
REQ-007 Port `load`  input  1  one-cycle strobe marking `data_in` valid.
REQ-008 Port `frame_tick`  input  1  one-cycle pulse per display frame.
REQ-009 Port `level`  output  8  ballistic bar level.
REQ-010 Port `peak`  output  8  peak-hold marker.
REQ-011 Port `hold_active`  output  1  high while the peak FSM is in HOLD.
REQ-012 Port `clip`  output  1  sticky clip flag; present only with the configuration macro defined.
REQ-013 Port `clip_clr`  input  1  clears `clip`; present only with the configuration macro defined.

Function
REQ-014 All outputs SHALL be registered, and SHALL update on the clock edge that samples `load` or `frame_tick` (latency 1 cycle).
REQ-015 Level attack: if `load` is high and `data_in` >= `level`, then `level` SHALL be set to `data_in`; this has priority over decay.
REQ-016 Level decay: otherwise, if `frame_tick` is high, `level` SHALL become `level` - DECAY_STEP, saturating at 0 and never wrapping.
REQ-017 `load` with `data_in` < `level` and no `frame_tick` SHALL leave `level` unchanged.
REQ-018 The peak FSM SHALL have 3 states, IDLE, HOLD and DECAY, encoded as 2 bits.
REQ-019 In any state, `load` with `data_in` >= `peak` SHALL set `peak` to `data_in`, load hold_cnt with HOLD_FRAMES, and enter HOLD. This includes `data_in` = 0 from IDLE.
REQ-020 In HOLD, `frame_tick` SHALL decrement hold_cnt; on the tick where hold_cnt = 1, the FSM SHALL enter DECAY. A peak capture on that same cycle SHALL win per REQ-019.
REQ-021 In DECAY, each `frame_tick` SHALL set `peak` to max(`peak` - 1, next `level`), saturating at 0.
REQ-022 When `peak` reaches 0, the FSM SHALL enter IDLE.
REQ-023 `peak` SHALL never be below `level`: when `level` rises above `peak`, REQ-019 applies on the same cycle.
REQ-024 When `load` and `frame_tick` occur in the same cycle, the sample SHALL be evaluated first. The tick SHALL apply only to state not overwritten by that sample.
REQ-025 `hold_active` SHALL equal (state == HOLD).

Reset
REQ-026 Asserting `reset` low SHALL immediately force `level` = 0, `peak` = 0, hold_cnt = 0, state = IDLE, `hold_active` = 0 and `clip` = 0, independent of `clock`.
REQ-027 Reset asserted mid-HOLD or mid-DECAY SHALL abandon the operation without a residual tick.
REQ-028 After reset deasserts, the first `load` SHALL be honoured on the next edge.
REQ-029 `enable` low SHALL NOT clear state, and SHALL NOT override `reset`.

Configuration
REQ-030 With macro PEAK_HOLD_CLIP_EN defined, `clip` SHALL be set on the edge after `load` with `data_in` = 255.
REQ-031 With PEAK_HOLD_CLIP_EN defined, `clip` SHALL stay set until the edge after `clip_clr` is high. Simultaneous set and clear SHALL leave `clip` = 1.
REQ-032 Without PEAK_HOLD_CLIP_EN, ports `clip` and `clip_clr` and the clip logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then `load` with `data_in` = 200 -> next cycle `level` = 200, `peak` = 200, `hold_active` = 1.
REQ-034 With `level` = 200 and DECAY_STEP = 4, 51 frame ticks -> `level` = 0 (saturated, not wrapped). With HOLD_FRAMES = 50, `peak` = 200 through tick 49, the FSM enters DECAY on tick 50, and `peak` = 199 on tick 51.
REQ-035 In DECAY with `peak` = 100, `load` with `data_in` = 120 and `frame_tick` in the same cycle -> `peak` = 120, state HOLD, hold_cnt = 50, `level` = 120.
REQ-036 With `level` = 10 and `peak` = 10 in DECAY, `load` with `data_in` = 3 and no tick -> no change; then a tick -> `level` = 6, `peak` = 9.
REQ-037 `reset` pulsed low mid-HOLD between clock edges -> all outputs 0 immediately, and IDLE after release.
REQ-038 With PEAK_HOLD_CLIP_EN defined, `load` with `data_in` = 255 -> `clip` = 1; `clip_clr` asserted in the same cycle as a second 255 sample -> `clip` stays 1; `clip_clr` alone -> `clip` = 0 next cycle.
